shift_register_ctrl: RTL and testbench

Command sequencer for the 4-bit universal shift register. It takes one command at a time over a valid/ready handshake: parallel load, or shift right/left by 0–7 positions with a selectable fill. It then drives the register's mode-select, serial-input and parallel-input pins cycle by cycle until the command completes. It sits beside the shift register, shares its CLK and Clear, and reads the register's `A_par` back for rotate and arithmetic fills.

---
 rtl/shift_register_ctrl.sv | 172 +++++++++++++++++
 tb/tb_shift_register_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_register_ctrl.sv
// ============================================================================
// Module   : shift_register_ctrl
// Purpose  : Command sequencer driving a 4-bit universal shift register
//            (parallel load, shift right/left 0-7 with zero/one/rotate/arith fill).
// Revision : 1.0
// ============================================================================
`default_nettype none

module shift_register_ctrl (
   input  logic       CLK,
   input  logic       Clear,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [1:0] cmd_fill,
   input  logic [2:0] cmd_count,
   input  logic [3:0] cmd_data,
   input  logic [3:0] A_par,
   output logic       s1,
   output logic       s0,
   output logic       MSB_in,
   output logic       LSB_in,
   output logic [3:0] I_par,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [1:0] OP_LOAD    = 2'b00;
   localparam logic [1:0] OP_SHR     = 2'b01;
   localparam logic [1:0] OP_SHL     = 2'b10;
   localparam logic [1:0] FILL_ZERO  = 2'b00;
   localparam logic [1:0] FILL_ONE   = 2'b01;
   localparam logic [1:0] FILL_ROT   = 2'b10;
   localparam logic [1:0] FILL_ARITH = 2'b11;

   state_t     state_q, state_d;
   logic [1:0] op_q, op_d;
   logic [1:0] fill_q, fill_d;
   logic [2:0] cnt_q, cnt_d;
   logic [3:0] ipar_q, ipar_d;

   logic       accept;
   logic       fill_right;
   logic       fill_left;

   assign cmd_ready = (state_q == S_IDLE) && !Clear;
   assign accept    = cmd_valid && cmd_ready;
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign I_par     = ipar_q;

   always_ff @(posedge CLK) begin
      if (Clear) begin
         state_q <= S_IDLE;
         op_q    <= 2'b00;
         fill_q  <= 2'b00;
         cnt_q   <= 3'd0;
         ipar_q  <= 4'b0000;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         fill_q  <= fill_d;
         cnt_q   <= cnt_d;
         ipar_q  <= ipar_d;
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      fill_d  = fill_q;
      cnt_d   = cnt_q;
      ipar_d  = ipar_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               op_d   = cmd_op;
               fill_d = cmd_fill;
               cnt_d  = cmd_count;
               ipar_d = cmd_data;
               if (cmd_op == OP_LOAD) begin
                  state_d = S_LOAD;
               end else if ((cmd_op == OP_SHR || cmd_op == OP_SHL) && (cmd_count != 3'd0)) begin
                  state_d = S_SHIFT;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_LOAD: begin
            state_d = S_DONE;
         end
         S_SHIFT: begin
            // The edge that consumes the last position also exits SHIFT.
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd1) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Fill bits follow the live register contents, not a snapshot at accept.
   always_comb begin
      fill_right = 1'b0;
      fill_left  = 1'b0;
      case (fill_q)
         FILL_ZERO: begin
            fill_right = 1'b0;
            fill_left  = 1'b0;
         end
         FILL_ONE: begin
            fill_right = 1'b1;
            fill_left  = 1'b1;
         end
         FILL_ROT: begin
            fill_right = A_par[0];
            fill_left  = A_par[3];
         end
         FILL_ARITH: begin
            fill_right = A_par[3];
            fill_left  = 1'b0;
         end
         default: begin
            fill_right = 1'b0;
            fill_left  = 1'b0;
         end
      endcase
   end

   always_comb begin
      s1     = 1'b0;
      s0     = 1'b0;
      MSB_in = 1'b0;
      LSB_in = 1'b0;
      case (state_q)
         S_LOAD: begin
            s1 = 1'b1;
            s0 = 1'b1;
         end
         S_SHIFT: begin
            s1 = op_q[1];
            s0 = op_q[0];
            if (op_q == OP_SHR) begin
               MSB_in = fill_right;
            end else if (op_q == OP_SHL) begin
               LSB_in = fill_left;
            end
         end
         default: begin
            s1 = 1'b0;
            s0 = 1'b0;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_shift_register_ctrl.sv
// ============================================================================
// Module   : tb_shift_register_ctrl
// Purpose  : Directed self-checking bench for shift_register_ctrl with a
//            behavioural 4-bit universal shift register closing the loop.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_shift_register_ctrl;

   logic       CLK;
   logic       Clear;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [1:0] cmd_fill;
   logic [2:0] cmd_count;
   logic [3:0] cmd_data;
   logic [3:0] A_par;
   logic       s1, s0, MSB_in, LSB_in;
   logic [3:0] I_par;
   logic       busy, done;

   int vectors    = 0;
   int miscompares = 0;

   shift_register_ctrl dut (
      .CLK       (CLK),
      .Clear     (Clear),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_fill  (cmd_fill),
      .cmd_count (cmd_count),
      .cmd_data  (cmd_data),
      .A_par     (A_par),
      .s1        (s1),
      .s0        (s0),
      .MSB_in    (MSB_in),
      .LSB_in    (LSB_in),
      .I_par     (I_par),
      .busy      (busy),
      .done      (done)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // The universal shift register the controller drives.
   always_ff @(posedge CLK) begin
      if (Clear) begin
         A_par <= 4'b0000;
      end else begin
         case ({s1, s0})
            2'b01:   A_par <= {MSB_in, A_par[3:1]};
            2'b10:   A_par <= {A_par[2:0], LSB_in};
            2'b11:   A_par <= I_par;
            default: A_par <= A_par;
         endcase
      end
   end

   // Issue one command from an idle controller and observe it to completion.
   // lat = edges after the accept edge at which done is seen; rdy = edge of ready return.
   task automatic run_cmd(input logic [1:0] op, input logic [1:0] fill, input logic [2:0] cnt,
                          input logic [3:0] data, output int lat, output int shifts,
                          output int loads, output int pulses, output int rdy);
      lat = -1; shifts = 0; loads = 0; pulses = 0; rdy = -1;
      vectors++;
      if (cmd_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL ready_before_accept: got %b want 1", cmd_ready);
      end
      cmd_valid = 1'b1; cmd_op = op; cmd_fill = fill; cmd_count = cnt; cmd_data = data;
      @(posedge CLK); #1;
      cmd_valid = 1'b0; cmd_op = 2'b11; cmd_fill = 2'b01; cmd_count = 3'd7; cmd_data = 4'b1111;
      for (int i = 0; i < 20; i++) begin
         if ({s1, s0} == 2'b11) loads++;
         if ((op == 2'b01 || op == 2'b10) && ({s1, s0} == op)) shifts++;
         if (done === 1'b1) begin
            pulses++;
            if (lat < 0) lat = i;
         end
         if (i > 0 && lat >= 0 && cmd_ready === 1'b1) begin
            rdy = i;
            break;
         end
         @(posedge CLK); #1;
      end
      vectors++;
      if (rdy < 0) begin
         miscompares++;
         $display("FAIL cmd_timeout: op=%b got no done/ready within 20 cycles", op);
      end
   endtask

   task automatic test_reset();
      Clear = 1'b1; cmd_valid = 1'b0;
      cmd_op = 2'b00; cmd_fill = 2'b00; cmd_count = 3'd0; cmd_data = 4'b0000;
      for (int c = 0; c < 2; c++) begin
         @(posedge CLK); #1;
         vectors++;
         if ({s1, s0, MSB_in, LSB_in} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_ctrl_pins: got s1s0/MSB/LSB=%b want 0000", {s1, s0, MSB_in, LSB_in});
         end
         vectors++;
         if (I_par !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_I_par: got %b want 0000", I_par);
         end
         vectors++;
         if ({busy, done, cmd_ready} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_status: got busy/done/ready=%b want 000", {busy, done, cmd_ready});
         end
      end
      Clear = 1'b0; #1;
      vectors++;
      if (cmd_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_ready_after: got %b want 1", cmd_ready);
      end
   endtask

   task automatic test_load();
      int lat, sh, ld, pu, rdy;
      run_cmd(2'b00, 2'b00, 3'd0, 4'b1010, lat, sh, ld, pu, rdy);
      vectors++;
      if (ld !== 1 || pu !== 1 || lat !== 1 || rdy !== 2) begin
         miscompares++;
         $display("FAIL load_timing: got loads=%0d pulses=%0d lat=%0d rdy=%0d want 1 1 1 2", ld, pu, lat, rdy);
      end
      vectors++;
      if (A_par !== 4'b1010 || I_par !== 4'b1010) begin
         miscompares++;
         $display("FAIL load_data: got A=%b I=%b want 1010 1010", A_par, I_par);
      end
   endtask

   task automatic test_shift(input string name, input logic [3:0] start, input logic [1:0] op,
                             input logic [1:0] fill, input logic [2:0] cnt, input logic [3:0] expect_a);
      int lat, sh, ld, pu, rdy;
      run_cmd(2'b00, 2'b00, 3'd0, start, lat, sh, ld, pu, rdy);
      run_cmd(op, fill, cnt, 4'b0000, lat, sh, ld, pu, rdy);
      vectors++;
      if (sh !== int'(cnt) || pu !== 1 || lat !== int'(cnt) || rdy !== int'(cnt) + 1) begin
         miscompares++;
         $display("FAIL %s_timing: got shifts=%0d pulses=%0d lat=%0d rdy=%0d want %0d 1 %0d %0d",
                  name, sh, pu, lat, rdy, cnt, cnt, cnt + 1);
      end
      vectors++;
      if (A_par !== expect_a) begin
         miscompares++;
         $display("FAIL %s_data: got %b want %b", name, A_par, expect_a);
      end
   endtask

   task automatic test_rotate();
      int lat, sh, ld, pu, rdy;
      test_shift("ror1", 4'b1011, 2'b01, 2'b10, 3'd1, 4'b1101);
      // Back-to-back from the resulting 1101: a full rotation leaves it unchanged.
      run_cmd(2'b01, 2'b10, 3'd4, 4'b0000, lat, sh, ld, pu, rdy);
      vectors++;
      if (sh !== 4 || pu !== 1 || lat !== 4 || rdy !== 5) begin
         miscompares++;
         $display("FAIL ror4_timing: got shifts=%0d pulses=%0d lat=%0d rdy=%0d want 4 1 4 5", sh, pu, lat, rdy);
      end
      vectors++;
      if (A_par !== 4'b1101) begin
         miscompares++;
         $display("FAIL ror4_data: got %b want 1101", A_par);
      end
      test_shift("rol1", 4'b1001, 2'b10, 2'b10, 3'd1, 4'b0011);
   endtask

   task automatic test_fills();
      test_shift("asr2", 4'b1000, 2'b01, 2'b11, 3'd2, 4'b1110);
      test_shift("shl_one3", 4'b0000, 2'b10, 2'b01, 3'd3, 4'b0111);
      test_shift("asl1", 4'b1001, 2'b10, 2'b11, 3'd1, 4'b0010);
      test_shift("shr_one2", 4'b0000, 2'b01, 2'b01, 3'd2, 4'b1100);
      test_shift("shr_zero7", 4'b1111, 2'b01, 2'b00, 3'd7, 4'b0000);
   endtask

   task automatic test_count0_nop();
      int lat, sh, ld, pu, rdy;
      run_cmd(2'b00, 2'b00, 3'd0, 4'b0110, lat, sh, ld, pu, rdy);
      run_cmd(2'b10, 2'b01, 3'd0, 4'b0110, lat, sh, ld, pu, rdy);
      vectors++;
      if (sh !== 0 || ld !== 0 || pu !== 1 || lat !== 0 || rdy !== 1 || A_par !== 4'b0110) begin
         miscompares++;
         $display("FAIL count0: got shifts=%0d loads=%0d pulses=%0d lat=%0d rdy=%0d A=%b want 0 0 1 0 1 0110",
                  sh, ld, pu, lat, rdy, A_par);
      end
      run_cmd(2'b11, 2'b01, 3'd5, 4'b0101, lat, sh, ld, pu, rdy);
      vectors++;
      if (ld !== 0 || pu !== 1 || lat !== 0 || rdy !== 1 || A_par !== 4'b0110) begin
         miscompares++;
         $display("FAIL nop: got loads=%0d pulses=%0d lat=%0d rdy=%0d A=%b want 0 1 0 1 0110",
                  ld, pu, lat, rdy, A_par);
      end
      vectors++;
      if (I_par !== 4'b0101) begin
         miscompares++;
         $display("FAIL nop_I_par: got %b want 0101", I_par);
      end
   endtask

   task automatic test_abort();
      int lat, sh, ld, pu, rdy;
      int extra_done;
      run_cmd(2'b00, 2'b00, 3'd0, 4'b1111, lat, sh, ld, pu, rdy);
      cmd_valid = 1'b1; cmd_op = 2'b01; cmd_fill = 2'b00; cmd_count = 3'd7; cmd_data = 4'b0000;
      @(posedge CLK); #1;
      // Offer a load while busy; it must be ignored.
      cmd_op = 2'b00; cmd_data = 4'b1010;
      vectors++;
      if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL abort_busy: got ready=%b busy=%b want 0 1", cmd_ready, busy);
      end
      repeat (3) begin
         @(posedge CLK); #1;
      end
      vectors++;
      if (A_par !== 4'b0001 || {s1, s0} !== 2'b01) begin
         miscompares++;
         $display("FAIL abort_3shifts: got A=%b s1s0=%b want 0001 01", A_par, {s1, s0});
      end
      cmd_valid = 1'b0; Clear = 1'b1;
      @(posedge CLK); #1;
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0 || {s1, s0} !== 2'b00 || A_par !== 4'b0000 || cmd_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_clear: got busy=%b done=%b s1s0=%b A=%b ready=%b want 0 0 00 0000 0",
                  busy, done, {s1, s0}, A_par, cmd_ready);
      end
      Clear = 1'b0; #1;
      vectors++;
      if (cmd_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL abort_ready: got %b want 1", cmd_ready);
      end
      extra_done = 0;
      repeat (4) begin
         @(posedge CLK); #1;
         if (done === 1'b1 || busy === 1'b1) extra_done++;
      end
      vectors++;
      if (extra_done !== 0 || A_par !== 4'b0000) begin
         miscompares++;
         $display("FAIL abort_quiet: got done/busy cycles=%0d A=%b want 0 0000", extra_done, A_par);
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_rotate();
      test_fills();
      test_count0_nop();
      test_abort();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
